fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Decoupling stage between the program counter (IF) and the decoder. Each cycle it issues the current PC to the synchronous instruction ROM, captures the returned 9-bit instruction tagged with its PC into a small FIFO, and presents it to decode with a valid/ready handshake. It back-pressures IF via `Fetch_stall`, flushes on taken branches, and raises `Done` once a halt has drained.

## Interface
- `DEPTH`, 2, FIFO entries (≥2).
- `PC_W`, 10, PC width.
- `INSTR_W`, 9, instruction width.

- `CLK`  in  1  clock; all state changes on posedge.
- `Init_n`  in  1  reset, synchronous, active-low.
- `PC`  in  PC_W  current PC from IF.
- `Halt_in`  in  1  IF halt flag for the current PC.
- `Branch_taken`  in  1  taken branch/jump this cycle; flush.
- `IM_addr`  out  PC_W  ROM read address.
- `IM_data`  in  INSTR_W  ROM data; valid one cycle after `IM_addr`.
- `Instr`  out  INSTR_W  head instruction.
- `Instr_PC`  out  PC_W  PC of `Instr`.
- `Instr_valid`  out  1  head valid.
- `Dec_ready`  in  1  decode accepts head; pop = `Instr_valid && Dec_ready`.
- `Fetch_stall`  out  1  IF must hold PC this cycle.
- `Done`  out  1  sticky; program drained after halt.

## Operation
- State: FIFO (`count`, 0..DEPTH), in-flight register (`inflight`, `inflight_pc`), `draining`, `Done`.
- `IM_addr = PC`, combinational, always.
- Issue when `!Fetch_stall && !draining && !Done && !Halt_in && !Branch_taken`: next cycle `inflight=1`, `inflight_pc=PC`; else `inflight=0`.
- Push: `inflight` set → {`IM_data`, `inflight_pc`} written at tail that cycle.
- `Fetch_stall = (count + inflight - pop) >= DEPTH`, computed with PC_W-independent 3-bit arithmetic. Also high while `draining` or `Done`.
- Push and pop in the same cycle: `count` unchanged, order preserved.
- `Branch_taken`: highest priority. Same edge: `count=0`, `inflight=0`, `draining=0`; that cycle's pop and push are discarded; no issue. `Done` is unaffected.
- `Halt_in` at an issue slot: no issue, `draining=1`. `Done` rises on the edge where `draining && count==0 && !inflight`, then holds until reset.
- Outputs `Instr`/`Instr_PC` show the head entry; both are 0 when empty.

## Timing
- Reset (`Init_n=0` at edge, including mid-operation): `count=0`, `inflight=0`, `draining=0`, `Done=0`; next cycle `Instr_valid=0`, `Instr=0`, `Instr_PC=0`, `Fetch_stall=0`.
- Latency, PC issued in cycle t: ROM data at t+1, FIFO write at end of t+1, `Instr_valid` at t+2 (t+1 with bypass, below).
- Sustained throughput: 1 instr/cycle while `Dec_ready=1`.
- Full: `count==DEPTH` with no pop → `Fetch_stall=1`; IF holds PC; no entries are lost or duplicated.
- Flush at cycle t with new PC `Target` at t+1: first post-branch `Instr_valid` at t+3 (t+2 with bypass).

## Configuration
- `FETCH_BUF_BYPASS_EN` defined: when `count==0 && inflight`, `Instr`/`Instr_PC`/`Instr_valid` are driven combinationally from `IM_data`/`inflight_pc`. If `Dec_ready`, the entry is consumed without a FIFO write; otherwise it is written normally.
- Not defined: every instruction passes through the FIFO; `Instr_valid` is driven purely from registers.

## Structure
- `fetch_pkg`: `PC_W`, `INSTR_W` defaults; `typedef struct packed {logic [INSTR_W-1:0] instr; logic [PC_W-1:0] pc;} fetch_entry_t`.
- Sub-module `fetch_fifo`: DEPTH-entry circular buffer of `fetch_entry_t` with push/pop/clear, `count`, head output. Pointers wrap mod DEPTH.
- Top level: in-flight register, stall math, drain/Done FSM (RUN → DRAIN → DONE; DRAIN→RUN on flush; DONE exits only on reset).

## Test plan
- Reset then stream, `Dec_ready=1`, PC 0,1,2…, ROM[i]=i+0x100 → `Instr_valid` from cycle 2, `Instr_PC`=0,1,2… back-to-back with matching data.
- `Dec_ready=0` for 5 cycles from cycle 3 → `Fetch_stall` high while full, `count` caps at DEPTH; on release, PCs continue with no gap or repeat.
- `Branch_taken` with 2 entries queued, IF jumps to 0x040 → queue empties next cycle, first valid `Instr_PC=0x040` at t+3 (t+2 with bypass).
- `Halt_in` at PC=9, `Dec_ready=1` → PC 9 never issued, PCs ≤8 delivered, `Done=1` one edge after drain, stays high.
- `Init_n=0` for one edge with full FIFO and `Done=1` → all outputs are at reset values next cycle and fetch restarts from the current PC.
- Push+pop in the same cycle at `count==1` → `count` stays 1, FIFO order intact, `Fetch_stall=0` for DEPTH=2.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch buffer: entry bundle, default widths and FSM states.
package fetch_pkg;

  localparam int PC_W_DFLT    = 10;
  localparam int INSTR_W_DFLT = 9;

  typedef struct packed {
    logic [INSTR_W_DFLT-1:0] instr;
    logic [PC_W_DFLT-1:0]    pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FB_RUN   = 2'd0,
    FB_DRAIN = 2'd1,
    FB_DONE  = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with push/pop/clear and a zeroed head when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t,
  parameter int  CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          Init_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  T              wdata,
  output T              head,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge CLK) begin
    if (!Init_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= nxt(wr_ptr);
      if (pop_ok)  rd_ptr <= nxt(rd_ptr);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Init_n && !clear && push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// IF-to-decode fetch buffer: ROM issue, in-flight tracking, FIFO, drain/Done FSM.
// Optional FETCH_BUF_BYPASS_EN forwards ROM data straight to decode when empty.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int PC_W    = PC_W_DFLT,
  parameter int INSTR_W = INSTR_W_DFLT
) (
  input  logic               CLK,
  input  logic               Init_n,
  input  logic [PC_W-1:0]    PC,
  input  logic               Halt_in,
  input  logic               Branch_taken,
  output logic [PC_W-1:0]    IM_addr,
  input  logic [INSTR_W-1:0] IM_data,
  output logic [INSTR_W-1:0] Instr,
  output logic [PC_W-1:0]    Instr_PC,
  output logic               Instr_valid,
  input  logic               Dec_ready,
  output logic               Fetch_stall,
  output logic               Done
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = ($clog2(DEPTH + 2) > 3) ? $clog2(DEPTH + 2) : 3;

  fb_state_e       state;
  logic            inflight;
  logic [PC_W-1:0] inflight_pc;
  logic [CW-1:0]   count;
  logic            empty;
  entry_t          head;
  entry_t          wdata;
  logic            pop;
  logic            push;
  logic            issue;
  logic            halt_slot;
  logic [SW-1:0]   occ;

  assign IM_addr = PC;
  assign wdata   = '{instr: IM_data, pc: inflight_pc};
  assign pop     = Instr_valid && Dec_ready;

`ifdef FETCH_BUF_BYPASS_EN
  logic byp;

  assign byp         = empty && inflight;
  assign Instr_valid = !empty || inflight;
  assign Instr       = byp ? IM_data : head.instr;
  assign Instr_PC    = byp ? inflight_pc : head.pc;
  // A bypassed word taken by decode this cycle never enters the FIFO.
  assign push        = inflight && !(byp && Dec_ready);
`else
  assign Instr_valid = !empty;
  assign Instr       = head.instr;
  assign Instr_PC    = head.pc;
  assign push        = inflight;
`endif

  assign occ = SW'(count) + SW'(inflight) - SW'(pop);

  assign Fetch_stall = (occ >= SW'(DEPTH)) || (state != FB_RUN);
  assign issue       = !Fetch_stall && !Halt_in && !Branch_taken;
  assign halt_slot   = !Fetch_stall && Halt_in && !Branch_taken;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t),
    .CW    (CW)
  ) u_fifo (
    .CLK   (CLK),
    .Init_n(Init_n),
    .clear (Branch_taken),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .head  (head),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge CLK) begin
    if (!Init_n) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= PC;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Init_n) begin
      state <= FB_RUN;
      Done  <= 1'b0;
    end else begin
      unique case (state)
        FB_RUN: begin
          if (halt_slot) state <= FB_DRAIN;
        end
        FB_DRAIN: begin
          if (Branch_taken) begin
            state <= FB_RUN;
          end else if (empty && !inflight) begin
            state <= FB_DONE;
            Done  <= 1'b1;
          end
        end
        FB_DONE: begin
          state <= FB_DONE;
        end
        default: begin
          state <= FB_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: IF/ROM model, streaming, stall, flush, halt, reset.
module tb_fetch_buffer;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int DEPTH   = 2;
`ifdef FETCH_BUF_BYPASS_EN
  localparam int LAT    = 1;
  localparam int BR_LAT = 2;
`else
  localparam int LAT    = 2;
  localparam int BR_LAT = 3;
`endif

  logic               CLK = 1'b0;
  logic               Init_n;
  logic [PC_W-1:0]    PC;
  logic               Halt_in;
  logic               Branch_taken;
  logic [PC_W-1:0]    IM_addr;
  logic [INSTR_W-1:0] IM_data;
  logic [INSTR_W-1:0] Instr;
  logic [PC_W-1:0]    Instr_PC;
  logic               Instr_valid;
  logic               Dec_ready;
  logic               Fetch_stall;
  logic               Done;

  fetch_buffer #(
    .DEPTH  (DEPTH),
    .PC_W   (PC_W),
    .INSTR_W(INSTR_W)
  ) dut (
    .CLK         (CLK),
    .Init_n      (Init_n),
    .PC          (PC),
    .Halt_in     (Halt_in),
    .Branch_taken(Branch_taken),
    .IM_addr     (IM_addr),
    .IM_data     (IM_data),
    .Instr       (Instr),
    .Instr_PC    (Instr_PC),
    .Instr_valid (Instr_valid),
    .Dec_ready   (Dec_ready),
    .Fetch_stall (Fetch_stall),
    .Done        (Done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pops = 0;
  int   last_pop_cyc = -1;
  logic [PC_W-1:0] last_pc;
  logic [PC_W-1:0] br_target;
  logic halt_en = 1'b0;

  logic               s_valid;
  logic               s_stall;
  logic               s_done;
  logic [INSTR_W-1:0] s_instr;
  logic [PC_W-1:0]    s_ipc;
  int                 s_cyc;

  assign Halt_in = halt_en && (PC == 10'd9);

  function automatic logic [INSTR_W-1:0] rom(input logic [PC_W-1:0] a);
    logic [PC_W-1:0] v;
    v = a + 10'h100;
    return v[INSTR_W-1:0];
  endfunction

  always @(posedge CLK) IM_data <= rom(IM_addr);

  // Scoreboard consumer: every accepted head must match the oldest issued PC.
  always @(negedge CLK) begin
    if (Init_n && !Branch_taken && Instr_valid && Dec_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got pc=%h instr=%h, required no entry",
                 Instr_PC, Instr);
      end else begin
        e = q.pop_front();
        if ({Instr_PC, Instr} !== {e.pc, e.instr}) begin
          errors++;
          $display("FAIL pop_data: got pc=%h instr=%h, required pc=%h instr=%h",
                   Instr_PC, Instr, e.pc, e.instr);
        end
      end
      pops++;
      last_pop_cyc = cyc;
      last_pc = Instr_PC;
    end
  end

  // One cycle of the IF model: hold on stall/halt, jump on branch, log issued PCs.
  task automatic tick();
    @(negedge CLK);
    s_valid = Instr_valid;
    s_stall = Fetch_stall;
    s_done  = Done;
    s_instr = Instr;
    s_ipc   = Instr_PC;
    s_cyc   = cyc;
    @(posedge CLK);
    #1;
    cyc++;
    if (!Init_n) begin
      q.delete();
    end else if (Branch_taken) begin
      q.delete();
      PC = br_target;
      Branch_taken = 1'b0;
    end else if (!s_stall && !Halt_in) begin
      q.push_back('{pc: PC, instr: rom(PC)});
      PC = PC + 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({Instr_valid, Instr, Instr_PC, Fetch_stall, Done} !== '0) begin
      errors++;
      $display("FAIL %s: got v=%b i=%h pc=%h st=%b d=%b, required all 0",
               tag, Instr_valid, Instr, Instr_PC, Fetch_stall, Done);
    end
  endtask

  task automatic test_reset();
    Init_n = 1'b0;
    PC = '0;
    Dec_ready = 1'b1;
    Branch_taken = 1'b0;
    br_target = '0;
    tick();
    tick();
    check_reset_outputs("reset_state");
    checks++;
    if (IM_addr !== PC) begin
      errors++;
      $display("FAIL im_addr: got %h, required %h", IM_addr, PC);
    end
    Init_n = 1'b1;
  endtask

  task automatic test_stream();
    int start;
    int first;
    start = cyc;
    first = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (s_valid && first < 0) first = s_cyc - start;
      checks++;
      if (s_stall !== 1'b0) begin
        errors++;
        $display("FAIL stream_stall: cycle %0d got %b, required 0", k, s_stall);
      end
      if (!s_valid) begin
        checks++;
        if ({s_instr, s_ipc} !== '0) begin
          errors++;
          $display("FAIL empty_head: got instr=%h pc=%h, required 0", s_instr, s_ipc);
        end
      end
    end
    checks++;
    if (first != LAT) begin
      errors++;
      $display("FAIL stream_latency: got %0d, required %0d", first, LAT);
    end
  endtask

  task automatic test_backpressure();
    int p0;
    Dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i >= 1) begin
        checks++;
        if (s_stall !== 1'b1) begin
          errors++;
          $display("FAIL full_stall: cycle %0d got %b, required 1", i, s_stall);
        end
      end
    end
    Dec_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({s_valid, s_stall} !== 2'b10) begin
        errors++;
        $display("FAIL release: cycle %0d got v=%b st=%b, required v=1 st=0",
                 i, s_valid, s_stall);
      end
    end
    checks++;
    if (pops - p0 != 6) begin
      errors++;
      $display("FAIL release_rate: got %0d pops, required 6", pops - p0);
    end
  endtask

  task automatic test_branch();
    int first;
    Dec_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (s_stall !== 1'b1 || s_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_branch: got st=%b v=%b, required 1 1", s_stall, s_valid);
    end
    br_target = 10'h040;
    Branch_taken = 1'b1;
    tick();
    Dec_ready = 1'b1;
    first = -1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin
        checks++;
        if (s_valid !== 1'b0) begin
          errors++;
          $display("FAIL flush_empty: got v=%b, required 0", s_valid);
        end
      end
      if (s_valid && first < 0) begin
        first = k;
        checks++;
        if (s_ipc !== 10'h040) begin
          errors++;
          $display("FAIL branch_target: got %h, required 040", s_ipc);
        end
      end
    end
    checks++;
    if (first != BR_LAT) begin
      errors++;
      $display("FAIL branch_latency: got %0d, required %0d", first, BR_LAT);
    end
  endtask

  task automatic test_halt();
    int done_cyc;
    halt_en = 1'b1;
    br_target = 10'd5;
    Branch_taken = 1'b1;
    tick();
    done_cyc = -1;
    for (int k = 0; k < 40 && done_cyc < 0; k++) begin
      tick();
      if (s_done) done_cyc = s_cyc;
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL halt_timeout: got no Done in 40 cycles, required Done");
    end else begin
      checks++;
      if (done_cyc != last_pop_cyc + 2) begin
        errors++;
        $display("FAIL done_timing: got cycle %0d, required %0d",
                 done_cyc, last_pop_cyc + 2);
      end
    end
    checks++;
    if (q.size() != 0 || last_pc !== 10'd8) begin
      errors++;
      $display("FAIL drain: got %0d left last pc=%h, required 0 left pc=008",
               q.size(), last_pc);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({s_done, s_stall, s_valid} !== 3'b110) begin
        errors++;
        $display("FAIL done_hold: got d=%b st=%b v=%b, required 1 1 0",
                 s_done, s_stall, s_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [PC_W-1:0] start_pc;
    int first;
    halt_en = 1'b0;
    Init_n = 1'b0;
    tick();
    Init_n = 1'b1;
    check_reset_outputs("reset_from_done");
    Dec_ready = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (s_stall !== 1'b1) begin
      errors++;
      $display("FAIL fill: got st=%b, required 1", s_stall);
    end
    Init_n = 1'b0;
    tick();
    Init_n = 1'b1;
    check_reset_outputs("reset_from_full");
    start_pc = PC;
    Dec_ready = 1'b1;
    first = -1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (s_valid && first < 0) begin
        first = k;
        checks++;
        if (s_ipc !== start_pc) begin
          errors++;
          $display("FAIL restart_pc: got %h, required %h", s_ipc, start_pc);
        end
      end
    end
    checks++;
    if (first != LAT) begin
      errors++;
      $display("FAIL restart_latency: got %0d, required %0d", first, LAT);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_halt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
